// File: rtl/nqueen_pkg.sv
// Shared constants for the N-queens solver: FSM state encodings, count width
// and the row/column index width helper.
package nqueen_pkg;

  localparam int SOL_W = 16;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_CHECK = 3'd1;
  localparam state_t ST_NEXT  = 3'd2;
  localparam state_t ST_EMIT  = 3'd3;
  localparam state_t ST_DONE  = 3'd4;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nqueen_conflict.sv
// Attack test between two queens given as (row, column) pairs: same column or
// same diagonal. Differences are taken one bit wider so they never wrap.
module nqueen_conflict #(
  parameter int W = 3
) (
  input  logic [W-1:0] row_a,
  input  logic [W-1:0] col_a,
  input  logic [W-1:0] row_b,
  input  logic [W-1:0] col_b,
  output logic         conflict
);

  logic [W:0] d_row;
  logic [W:0] d_col;

  always_comb begin
    d_row = (row_a > row_b) ? ({1'b0, row_a} - {1'b0, row_b})
                            : ({1'b0, row_b} - {1'b0, row_a});
    d_col = (col_a > col_b) ? ({1'b0, col_a} - {1'b0, col_b})
                            : ({1'b0, col_b} - {1'b0, col_a});
    conflict = (col_a == col_b) || (d_row == d_col);
  end

endmodule

// File: rtl/nqueen_solver.sv
// Backtracking N-queens engine streaming each solution row by row over
// valid/ready. Define NQUEEN_SOL_COUNT_EN to build the saturating solution counter.
module nqueen_solver
  import nqueen_pkg::*;
#(
  parameter int N = 8,
  parameter int W = idx_width(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_bus,
  output logic [W-1:0]     out_row,
  output logic             out_last,
  output logic [SOL_W-1:0] sol_count
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  state_t       state;
  logic [W-1:0] r;
  logic [W-1:0] k;
  logic [W-1:0] e;
  logic [W-1:0] col [N];
  logic         conflict;
  logic         launch;

  assign launch = ((state == ST_IDLE) || (state == ST_DONE)) && start;

  // Newest queen (row r) against earlier row k, one pair per CHECK cycle.
  nqueen_conflict #(.W(W)) u_conflict (
    .row_a    (k),
    .col_a    (col[k]),
    .row_b    (r),
    .col_b    (col[r]),
    .conflict (conflict)
  );

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      r     <= '0;
      k     <= '0;
      e     <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state <= ST_CHECK;
            r     <= '0;
            k     <= '0;
          end
        end
        ST_CHECK: begin
          if (k == r) begin
            if (r == LAST) begin
              e     <= '0;
              state <= ST_EMIT;
            end else begin
              r <= r + 1'b1;
              k <= '0;
            end
          end else if (conflict) begin
            state <= ST_NEXT;
          end else begin
            k <= k + 1'b1;
          end
        end
        ST_NEXT: begin
          if (col[r] == LAST) begin
            if (r == '0) state <= ST_DONE;
            else         r     <= r - 1'b1;
          end else begin
            k     <= '0;
            state <= ST_CHECK;
          end
        end
        ST_EMIT: begin
          if (out_ready) begin
            if (e == LAST) state <= ST_NEXT;
            else           e     <= e + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: the board array carries no reset; every entry is written (cleared)
  // before the FSM first reads it, so resetting it would only add fan-out.
  always_ff @(posedge clk) begin
    case (state)
      ST_IDLE, ST_DONE: if (start) col[0] <= '0;
      ST_CHECK:         if ((k == r) && (r != LAST)) col[r + 1'b1] <= '0;
      ST_NEXT:          if (col[r] != LAST) col[r] <= col[r] + 1'b1;
      default: ;
    endcase
  end

`ifdef NQUEEN_SOL_COUNT_EN
  logic [SOL_W-1:0] sol_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sol_cnt <= '0;
    end else if (launch) begin
      sol_cnt <= '0;
    end else if ((state == ST_EMIT) && out_ready && (e == LAST) && (sol_cnt != '1)) begin
      sol_cnt <= sol_cnt + 1'b1;
    end
  end

  assign sol_count = sol_cnt;
`else
  assign sol_count = '0;
`endif

  // Outputs decode state and index registers only; out_ready never reaches them.
  assign busy      = (state == ST_CHECK) || (state == ST_NEXT) || (state == ST_EMIT);
  assign done      = (state == ST_DONE);
  assign out_valid = (state == ST_EMIT);
  assign out_row   = out_valid ? e : '0;
  assign out_bus   = out_valid ? (N'(1) << col[e]) : '0;
  assign out_last  = out_valid && (e == LAST);

endmodule

// File: tb/tb_nqueen_solver.sv
// Scoreboard bench for nqueen_solver at N = 4, 8, 3 and 1: stimulus pushes
// expected beats, per-instance monitors pop and compare on every accepted row.
module tb_nqueen_solver;
  import nqueen_pkg::*;

  typedef struct packed {
    logic [15:0] bus;
    logic [3:0]  row;
    logic        last;
  } beat_t;

`ifdef NQUEEN_SOL_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  localparam int LIMIT = 90000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic rst_all = 1'b0;
  logic rst8    = 1'b1;
  logic st4 = 1'b0, st8 = 1'b0, st3 = 1'b0, st1 = 1'b0;
  logic stall4 = 1'b0;
  logic rdy4   = 1'b1;

  logic bsy4, dn4, v4, last4; logic [3:0] bus4; logic [1:0] row4; logic [15:0] cnt4;
  logic bsy8, dn8, v8, last8; logic [7:0] bus8; logic [2:0] row8; logic [15:0] cnt8;
  logic bsy3, dn3, v3, last3; logic [2:0] bus3; logic [1:0] row3; logic [15:0] cnt3;
  logic bsy1, dn1, v1, last1; logic [0:0] bus1; logic [0:0] row1; logic [15:0] cnt1;

  nqueen_solver #(.N(4)) u4 (
    .clk(clk), .reset(rst_all), .start(st4), .busy(bsy4), .done(dn4),
    .out_valid(v4), .out_ready(rdy4), .out_bus(bus4), .out_row(row4),
    .out_last(last4), .sol_count(cnt4)
  );
  nqueen_solver #(.N(8)) u8 (
    .clk(clk), .reset(rst_all & rst8), .start(st8), .busy(bsy8), .done(dn8),
    .out_valid(v8), .out_ready(1'b1), .out_bus(bus8), .out_row(row8),
    .out_last(last8), .sol_count(cnt8)
  );
  nqueen_solver #(.N(3)) u3 (
    .clk(clk), .reset(rst_all), .start(st3), .busy(bsy3), .done(dn3),
    .out_valid(v3), .out_ready(1'b1), .out_bus(bus3), .out_row(row3),
    .out_last(last3), .sol_count(cnt3)
  );
  nqueen_solver #(.N(1)) u1 (
    .clk(clk), .reset(rst_all), .start(st1), .busy(bsy1), .done(dn1),
    .out_valid(v1), .out_ready(1'b1), .out_bus(bus1), .out_row(row1),
    .out_last(last1), .sol_count(cnt1)
  );

  beat_t q4[$], q8[$], q3[$], q1[$];
  string names [4] = '{"u4", "u8", "u3", "u1"};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_beat(input int id, input int row, input int c, input bit last);
    beat_t b;
    b = '{bus: 16'(1) << c, row: 4'(row), last: last};
    case (id)
      0:       q4.push_back(b);
      1:       q8.push_back(b);
      2:       q3.push_back(b);
      default: q1.push_back(b);
    endcase
  endtask

  task automatic push4(input int c0, input int c1, input int c2, input int c3);
    push_beat(0, 0, c0, 1'b0);
    push_beat(0, 1, c1, 1'b0);
    push_beat(0, 2, c2, 1'b0);
    push_beat(0, 3, c3, 1'b1);
  endtask

  // Reference: walk column permutations in lexicographic order, keep non-attacking ones.
  task automatic push_model8();
    int  p [8];
    int  i, j, t;
    bit  ok;
    for (int a = 0; a < 8; a++) p[a] = a;
    forever begin
      ok = 1'b1;
      for (int a = 0; a < 8; a++)
        for (int b = a + 1; b < 8; b++)
          if ((p[a] - p[b] == b - a) || (p[b] - p[a] == b - a)) ok = 1'b0;
      if (ok)
        for (int a = 0; a < 8; a++) push_beat(1, a, p[a], a == 7);
      i = 6;
      while (i >= 0 && p[i] > p[i + 1]) i--;
      if (i < 0) break;
      j = 7;
      while (p[j] < p[i]) j--;
      t = p[i]; p[i] = p[j]; p[j] = t;
      for (int a = i + 1, b = 7; a < b; a++, b--) begin
        t = p[a]; p[a] = p[b]; p[b] = t;
      end
    end
  endtask

  task automatic mon_beat(input int id, input logic [15:0] bus, input logic [3:0] row, input logic last);
    beat_t act_b, exp_b;
    int    depth;
    act_b = '{bus: bus, row: row, last: last};
    case (id)
      0:       depth = q4.size();
      1:       depth = q8.size();
      2:       depth = q3.size();
      default: depth = q1.size();
    endcase
    if (depth == 0) begin
      tests++;
      fails++;
      $display("FAIL %s extra beat: got row %0d bus 0x%0h last %0b, expected none",
               names[id], row, bus, last);
    end else begin
      case (id)
        0:       exp_b = q4.pop_front();
        1:       exp_b = q8.pop_front();
        2:       exp_b = q3.pop_front();
        default: exp_b = q1.pop_front();
      endcase
      check({names[id], " beat"}, 32'(act_b), 32'(exp_b));
    end
  endtask

  function automatic int oh_idx(input logic [15:0] b);
    for (int i = 0; i < 16; i++)
      if (b == (16'(1) << i)) return i;
    return 0;
  endfunction

  function automatic logic done_of(input int id);
    case (id)
      0:       return dn4;
      1:       return dn8;
      2:       return dn3;
      default: return dn1;
    endcase
  endfunction

  task automatic wait_done(input int id);
    int n;
    n = 0;
    while (!done_of(id) && n < LIMIT) begin
      tick();
      n++;
    end
    check({names[id], " done reached"}, 32'(done_of(id)), 32'd1);
  endtask

  // Random backpressure for the N=4 instance, changed just after each edge.
  always @(posedge clk) begin
    #1;
    rdy4 = stall4 ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  int          sol4 = 0;
  int          sol8 = 0;
  logic        ever_v3 = 1'b0;
  logic        stalled4 = 1'b0;
  logic [6:0]  held4 = '0;
  logic [23:0] cur8 = '0, first8 = '0, final8 = '0;

  always @(negedge clk) begin
    if (stalled4) begin
      check("u4 stall valid held", 32'(v4), 32'd1);
      check("u4 stall data held", 32'({bus4, row4, last4}), 32'(held4));
    end
    stalled4 = v4 && !rdy4;
    held4    = {bus4, row4, last4};
    if (v4 && rdy4) begin
      mon_beat(0, 16'(bus4), 4'(row4), last4);
      if (last4) sol4++;
    end
  end

  always @(negedge clk) begin
    if (!rst8) begin
      sol8 = 0;
    end else if (v8) begin
      mon_beat(1, 16'(bus8), 4'(row8), last8);
      cur8[21 - 3 * int'(row8) +: 3] = 3'(oh_idx(16'(bus8)));
      if (last8) begin
        sol8++;
        if (sol8 == 1) first8 = cur8;
        final8 = cur8;
      end
    end
  end

  always @(negedge clk) begin
    if (v3) ever_v3 = 1'b1;
    if (v1) mon_beat(3, 16'(bus1), 4'(row1), last1);
  end

  initial begin
    int n;
    int base;

    repeat (3) tick();
    check("u4 reset outputs", 32'({bsy4, dn4, v4, bus4, row4, last4}), 32'd0);
    check("u4 reset count", 32'(cnt4), 32'd0);
    check("u8 reset outputs", 32'({bsy8, dn8, v8, bus8, row8, last8}), 32'd0);
    rst_all = 1'b1;
    tick();

    // N=4, ready held high.
    push4(1, 3, 0, 2);
    push4(2, 0, 3, 1);
    st4 = 1'b1; tick(); st4 = 1'b0;
    check("u4 busy after start", 32'({bsy4, dn4}), 32'b10);
    wait_done(0);
    check("u4 solutions", 32'(sol4), 32'd2);
    check("u4 queue drained", 32'(q4.size()), 32'd0);
    check("u4 sol_count", 32'(cnt4), CNT_EN ? 32'd2 : 32'd0);

    // N=4 again from DONE, with random stalls.
    stall4 = 1'b1;
    push4(1, 3, 0, 2);
    push4(2, 0, 3, 1);
    st4 = 1'b1; tick(); st4 = 1'b0;
    wait_done(0);
    stall4 = 1'b0;
    check("u4 stalled solutions", 32'(sol4), 32'd4);
    check("u4 stalled queue drained", 32'(q4.size()), 32'd0);
    check("u4 stalled sol_count", 32'(cnt4), CNT_EN ? 32'd2 : 32'd0);

    // N=3: no solution.
    st3 = 1'b1; tick(); st3 = 1'b0;
    wait_done(2);
    check("u3 valid never seen", 32'(ever_v3), 32'd0);
    check("u3 sol_count", 32'(cnt3), 32'd0);

    // N=1: single beat.
    push_beat(3, 0, 0, 1'b1);
    st1 = 1'b1; tick(); st1 = 1'b0;
    wait_done(3);
    check("u1 queue drained", 32'(q1.size()), 32'd0);
    check("u1 sol_count", 32'(cnt1), CNT_EN ? 32'd1 : 32'd0);

    // N=8 full search with a start pulse while busy.
    push_model8();
    st8 = 1'b1; tick(); st8 = 1'b0;
    n = 0;
    while (sol8 < 1 && n < LIMIT) begin tick(); n++; end
    check("u8 first solution seen", 32'(sol8 >= 1), 32'd1);
    check("u8 busy mid-search", 32'(bsy8), 32'd1);
    st8 = 1'b1; tick(); st8 = 1'b0;
    wait_done(1);
    check("u8 solutions", 32'(sol8), 32'd92);
    check("u8 first solution", 32'(first8),
          32'({3'd0, 3'd4, 3'd7, 3'd5, 3'd2, 3'd6, 3'd1, 3'd3}));
    check("u8 last solution", 32'(final8),
          32'({3'd7, 3'd3, 3'd0, 3'd2, 3'd5, 3'd1, 3'd6, 3'd4}));
    check("u8 queue drained", 32'(q8.size()), 32'd0);
    check("u8 sol_count", 32'(cnt8), CNT_EN ? 32'd92 : 32'd0);

    // N=8 restart from DONE, then reset during the third solution's emit.
    push_model8();
    base = sol8;
    st8 = 1'b1; tick(); st8 = 1'b0;
    check("u8 restart busy/done", 32'({bsy8, dn8}), 32'b10);
    n = 0;
    while (!(sol8 == base + 2 && v8 && row8 == 3'd3) && n < LIMIT) begin tick(); n++; end
    check("u8 third solution mid-emit", 32'({v8, row8}), 32'({1'b1, 3'd3}));
    rst8 = 1'b0;
    #1;
    check("u8 async reset outputs", 32'({bsy8, dn8, v8, bus8, row8, last8}), 32'd0);
    check("u8 async reset count", 32'(cnt8), 32'd0);
    q8.delete();
    tick();
    rst8 = 1'b1;
    tick();
    for (int a = 0; a < 8; a++)
      push_beat(1, a, (a == 0) ? 0 : (a == 1) ? 4 : (a == 2) ? 7 : (a == 3) ? 5 :
                      (a == 4) ? 2 : (a == 5) ? 6 : (a == 6) ? 1 : 3, a == 7);
    st8 = 1'b1; tick(); st8 = 1'b0;
    n = 0;
    while (sol8 < 1 && n < LIMIT) begin tick(); n++; end
    check("u8 post-reset first solution", 32'(first8),
          32'({3'd0, 3'd4, 3'd7, 3'd5, 3'd2, 3'd6, 3'd1, 3'd3}));
    check("u8 post-reset queue drained", 32'(q8.size()), 32'd0);
    rst8 = 1'b0;
    tick();
    rst8 = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/nqueen_solver.md
# nqueen_solver

Parametrised N-queens search engine; next generation of the fixed 8×8 queen datapath. It stores one column index per row and runs a backtracking FSM that checks the newest queen against earlier rows one row per cycle. Every solution found is streamed out row by row over a valid/ready handshake. It sits beside the board controller as a self-contained solver: `start` in, solutions and `done` out.

## Interface
- `N`, default 8: board size and queen count; legal range 1..16.
- `W`, default `$clog2(N)` with a minimum of 1: column and row index width. Derived; do not override.
- `clk`, in, 1: single clock; all state changes on the rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: begin a new search. Sampled only in IDLE or DONE; ignored while `busy`.
- `busy`, out, 1: high in every state except IDLE and DONE.
- `done`, out, 1: high in DONE; held until the next accepted `start` or reset.
- `out_valid`, out, 1: a solution row is presented.
- `out_ready`, in, 1: the consumer accepts the presented row.
- `out_bus`, out, N: one-hot column of the queen in `out_row`; bit c means column c.
- `out_row`, out, W: row index of the presented row.
- `out_last`, out, 1: the presented row is N-1.
- `sol_count`, out, 16: number of solutions emitted so far (see Configuration).

## Operation
- Storage: `col[0..N-1]` (W bits each), current row `r`, check index `k`, emit index `e`.
- States:
  - IDLE: on `start`, clear r, k, `col[0]` and `sol_count`; go to CHECK.
  - CHECK, one earlier row per cycle:
    - If k == r, the queen is safe. If r == N-1, set e = 0 and go to EMIT. Otherwise r++, `col[r+1]` = 0, k = 0, stay in CHECK.
    - Else if `col[k]` == `col[r]`, or |r−k| == |`col[r]`−`col[k]`|, go to NEXT.
    - Else k++.
  - NEXT:
    - If `col[r]` == N-1: if r == 0, go to DONE; otherwise r-- and stay in NEXT (backtrack).
    - Else `col[r]`++, k = 0, go to CHECK.
  - EMIT: `out_valid` = 1, `out_row` = e, `out_bus` = 1 << `col[e]`, `out_last` = (e == N-1).
    - On `out_valid` && `out_ready`: e++.
    - On the beat where `out_last` is accepted: `sol_count`++ and go to NEXT, which continues the search from row N-1.
  - DONE: `done` = 1. An accepted `start` restarts exactly as from IDLE.
- Arithmetic:
  - Diagonal test uses W+1-bit unsigned absolute differences, so there is no wrap.
  - `sol_count` saturates at 0xFFFF.
- Search order: solutions are produced in lexicographic order of (`col[0]`, …, `col[N-1]`).
- N == 1: the first CHECK cycle goes straight to EMIT. One solution, column 0.
- N == 2 or 3: no solution exists. Reach DONE with `out_valid` never asserted.

## Timing
- Reset values: state IDLE; `busy` 0, `done` 0, `out_valid` 0, `out_bus` 0, `out_row` 0, `out_last` 0, `sol_count` 0.
- Reset asserted mid-search or mid-emit forces these values immediately. Any partial solution is lost.
- `start` accepted at edge T: `busy` = 1 from T+1 and `done` falls at T+1.
- `out_*` are registered or decoded from registers only; no combinational path from `out_ready` to any output.
- Backpressure:
  - While `out_valid` && !`out_ready`, `out_bus`, `out_row` and `out_last` hold stable and the search is frozen.
  - Once asserted, `out_valid` never drops before acceptance.
- Back-to-back accept: with `out_ready` held high, one row is transferred per cycle, so a full solution takes N cycles.
- `out_valid` falls the cycle after the last row is accepted.
- `start` in the same cycle as DONE entry is ignored; `start` is sampled from the cycle after.

## Configuration
- `NQUEEN_SOL_COUNT_EN` defined: the 16-bit saturating counter is built and drives `sol_count`.
- Undefined: no counter flops; `sol_count` is tied to 0.
- The port list is identical in both builds.

## Structure
- `nqueen_pkg` holds:
  - the state enum: IDLE, CHECK, NEXT, EMIT, DONE;
  - the index-width function (`$clog2` with a minimum of 1);
  - the `sol_count` width constant (16).
- Sub-module `nqueen_conflict`: combinational. Inputs are two (row, column) pairs of width W; output is `conflict` (same column or same diagonal). Instantiated once in the CHECK path.
- Everything else stays in `nqueen_solver`.

## Test plan
- N=4, `out_ready` tied high, pulse `start`:
  - two solutions, first columns 1,3,0,2 then 2,0,3,1;
  - `out_last` on rows 3;
  - `done` rises and `sol_count` = 2 (macro on).
- N=8, `out_ready` high:
  - 92 solutions;
  - first is 0,4,7,5,2,6,1,3; last is 7,3,0,2,5,1,6,4;
  - `sol_count` = 92 at `done`.
- N=4 with random `out_ready` stalls:
  - `out_bus`, `out_row` and `out_last` stable while stalled;
  - no row dropped or duplicated;
  - same two solutions as above.
- N=3:
  - `done` asserted, `out_valid` never high, `sol_count` = 0.
- N=1:
  - single beat, `out_bus` = 1, `out_row` = 0, `out_last` = 1; then `done`.
- N=8, assert `reset` low during the 3rd solution's EMIT:
  - all outputs return to reset values immediately;
  - a following `start` reproduces the first solution 0,4,7,5,2,6,1,3;
  - `start` pulsed while `busy` is ignored.
